gyro_fir_sequencer: RTL
=======================

Name: gyro_fir_sequencer

Overview:
- Time-multiplexed controller for the gyro 10-tap high-pass FIR.
- Each accepted IMU sample set (X/Y/Z) is written into per-axis circular history buffers. One shared multiply-accumulate unit is then stepped through 3 axes × 10 taps.
- Filtered results are published together with a one-cycle DataReady pulse.
- Sits between the IMU I2C reader (SampleValid) and the attitude/motor-control consumers. It replaces the per-edge combinational 30-multiplier filter with a single-clock, single-MAC schedule.

Parameters:
- TAPS, 10, filter length and history depth per axis.
- DW, 10, signed sample and output width.
- CW, 16, signed coefficient width (Q1.15).
- AW, 30, accumulator width: DW+CW+ceil(log2(TAPS)).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- SampleValid  in  1  one-cycle strobe: GyroX/Y/Z are valid.
- GyroX  in  DW  signed raw X rate.
- GyroY  in  DW  signed raw Y rate.
- GyroZ  in  DW  signed raw Z rate.
- ClearOverrun  in  1  clears the Overrun flag.
- GyroXOut  out  DW  signed filtered X.
- GyroYOut  out  DW  signed filtered Y.
- GyroZOut  out  DW  signed filtered Z.
- DataReady  out  1  one-cycle pulse: all three outputs updated.
- Busy  out  1  high while a filter pass is in progress.
- Primed  out  1  high once TAPS samples have been accepted since reset.
- Overrun  out  1  sticky flag: a sample was dropped while Busy.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high, named Reset.
- Reset values:
  - All outputs 0.
  - History buffers cleared to 0; write pointer 0; accepted-sample counter 0.
  - State IDLE.
- Reset mid-pass aborts the pass. No DataReady is issued for the aborted pass.
- States: IDLE, MAC, STORE.
- Accept (edge 0):
  - Condition: state IDLE and SampleValid=1.
  - Write GyroX/Y/Z at WrPtr, then advance WrPtr mod TAPS.
  - Clear the accumulator, set axis=0, tap=0, go to MAC.
- MAC:
  - Each edge: acc += COEF[tap] * hist[axis][(newest - tap) mod TAPS], where newest is the just-written slot.
  - tap increments each edge. After tap = TAPS-1, go to STORE.
- STORE (one edge):
  - Write the rounded/saturated result into the staging register for the axis.
  - If axis < 2: axis++, clear acc, tap=0, return to MAC.
  - Else: copy all three staging registers to GyroXOut/YOut/ZOut, pulse DataReady, go to IDLE.
- Timing:
  - MAC X on edges 1–10, STORE X on 11.
  - MAC Y on 12–21, STORE Y on 22.
  - MAC Z on 23–32, STORE Z on 33.
  - DataReady is high in the cycle following edge 33.
  - Latency 33 cycles. Minimum accept-to-accept spacing 34 cycles.
- Outputs change only at the STORE-Z edge, all three simultaneously. They hold between passes.
- Busy = (state != IDLE). It is registered and high from edge 0 through edge 33.
- Arithmetic:
  - Product is signed CW×DW, sign-extended to AW. No intermediate overflow is possible.
  - Result = (acc + 2^14) >>> 15 (arithmetic shift, round half up), then saturated to [-512, 511].
- Primed: set at the edge that accepts the TAPS-th sample since reset. Stays set until Reset.
- Before Primed, missing history taps read as 0. Outputs are valid numerically but reflect a filter transient.
- Overrun: SampleValid=1 while Busy drops the sample (buffer and pointer unchanged) and sets Overrun.
- ClearOverrun clears Overrun. If a set and a clear happen on the same edge, set wins.
- SampleValid held high continuously: one accept per 34 cycles. Each strobe seen while Busy counts as an overrun.

Decomposition:
- Package gyro_fir_pkg:
  - TAPS, DW, CW, AW constants.
  - State enum {IDLE, MAC, STORE}.
  - COEF[0:9] = fda5, 0e32, d54b, 52ed, 8e58, 71a8, ad13, 2ab5, f1ce, 025b (hex, signed). The taps are antisymmetric; the DC sum is 0.
  - Rounding/saturation function.
- Sub-module gyro_fir_mac:
  - Signed CW×DW multiply plus AW accumulator.
  - Inputs: clear and enable.
  - Registered acc output.

Test Plan:
- Impulse: reset, accept X=256, then 9 accepts of X=0 → GyroXOut sequence -5, 28, -85, 166, -227, 227, -166, 85, -28, 5. Y/Z stay 0.
- DC rejection: 12 accepts of X=Y=Z=100 → outputs 0 from the 10th DataReady onward. Primed rises at the 10th accept edge.
- Latency/handshake: accept at edge 0 → Busy high for edges 0–33. DataReady is exactly one cycle, after edge 33. Outputs change only then.
- Saturation: alternating history (−512 at even taps, +511 at odd taps relative to newest) → GyroXOut = 511. Inverted pattern → −512.
- Overrun: SampleValid at edge 5 of a pass → sample dropped, Overrun=1, next output unaffected. ClearOverrun together with a new drop → Overrun stays 1. ClearOverrun alone → 0.
- Reset mid-pass: Reset at edge 15 → next cycle Busy=0, outputs 0, no DataReady. A new accept restarts with a cleared history.

Source files
------------

// File: rtl/gyro_fir_pkg.sv
// Shared constants, state encoding, coefficient table and output rounding for the
// time-multiplexed gyro high-pass FIR.
package gyro_fir_pkg;

    localparam int TAPS     = 10;
    localparam int DW       = 10;
    localparam int CW       = 16;
    localparam int AW       = 30;
    localparam int NUM_AXES = 3;
    localparam int PW       = $clog2(TAPS);
    localparam int FRAC     = CW - 1;

    typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;

    // Antisymmetric Q1.15 taps; their sum is exactly zero, so DC is rejected.
    localparam logic [0:TAPS-1][CW-1:0] COEF = {
        16'hfda5, 16'h0e32, 16'hd54b, 16'h52ed, 16'h8e58,
        16'h71a8, 16'had13, 16'h2ab5, 16'hf1ce, 16'h025b
    };

    localparam logic signed [AW-1:0] OUT_HI = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] OUT_LO = -OUT_HI - AW'(1);

    function automatic logic signed [CW-1:0] coef_at(input logic [PW-1:0] idx);
        return $signed(COEF[idx]);
    endfunction

    // Round half up out of Q15, then clamp into the signed DW-bit output range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] r;
        r = (acc + AW'(1 << (FRAC - 1))) >>> FRAC;
        if (r > OUT_HI)
            return OUT_HI[DW-1:0];
        else if (r < OUT_LO)
            return OUT_LO[DW-1:0];
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/gyro_fir_mac.sv
// Single signed CW x DW multiplier feeding an AW-bit accumulator; clear has priority
// over enable.
module gyro_fir_mac
    import gyro_fir_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] sample,
    output logic signed [AW-1:0] acc
);

    logic signed [CW+DW-1:0] prod;
    logic signed [AW-1:0]    prod_ext;

    assign prod     = coef * sample;
    assign prod_ext = {{(AW - CW - DW){prod[CW+DW-1]}}, prod};

    always_ff @(posedge Clock) begin
        if (Reset || clear)
            acc <= '0;
        else if (enable)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/gyro_fir_sequencer.sv
// Accepts X/Y/Z sample sets into circular histories and steps one shared MAC through
// 3 axes x TAPS taps, publishing all three filtered values together.
module gyro_fir_sequencer
    import gyro_fir_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SampleValid,
    input  logic signed [DW-1:0] GyroX,
    input  logic signed [DW-1:0] GyroY,
    input  logic signed [DW-1:0] GyroZ,
    input  logic                 ClearOverrun,
    output logic signed [DW-1:0] GyroXOut,
    output logic signed [DW-1:0] GyroYOut,
    output logic signed [DW-1:0] GyroZOut,
    output logic                 DataReady,
    output logic                 Busy,
    output logic                 Primed,
    output logic                 Overrun
);

    localparam logic [PW-1:0] LAST_TAP  = PW'(TAPS - 1);
    localparam logic [1:0]    LAST_AXIS = 2'(NUM_AXES - 1);
    localparam logic [PW:0]   TAPS_W    = (PW + 1)'(TAPS);

    state_t               state, state_nx;
    logic [PW-1:0]        tap, wr_ptr, newest, rd_idx, n_acc;
    logic [PW:0]          rd_sum;
    logic [1:0]           axis;
    logic                 accept, mac_en, acc_clr, publish, drop;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] res, sample;
    logic signed [DW-1:0] gyro_in [NUM_AXES];
    logic signed [DW-1:0] tap_val [NUM_AXES];
    logic signed [DW-1:0] stg_val [NUM_AXES];

    assign gyro_in[0] = GyroX;
    assign gyro_in[1] = GyroY;
    assign gyro_in[2] = GyroZ;

    // Slot holding the sample 'tap' steps older than the newest one.
    assign rd_sum = {1'b0, newest} + TAPS_W - {1'b0, tap};
    assign rd_idx = (rd_sum >= TAPS_W) ? PW'(rd_sum - TAPS_W) : rd_sum[PW-1:0];

    assign drop = SampleValid && (state != IDLE);
    assign Busy = (state != IDLE);
    assign res  = round_sat(acc);

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        mac_en   = 1'b0;
        acc_clr  = 1'b0;
        publish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (SampleValid) begin
                    accept   = 1'b1;
                    acc_clr  = 1'b1;
                    state_nx = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap == LAST_TAP)
                    state_nx = STORE;
            end
            STORE: begin
                if (axis != LAST_AXIS) begin
                    acc_clr  = 1'b1;
                    state_nx = MAC;
                end else begin
                    publish  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tap  <= '0;
            axis <= '0;
        end else if (accept) begin
            tap  <= '0;
            axis <= '0;
        end else if (state == MAC) begin
            tap <= (tap == LAST_TAP) ? '0 : tap + 1'b1;
        end else if (state == STORE && axis != LAST_AXIS) begin
            tap  <= '0;
            axis <= axis + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            newest <= '0;
            n_acc  <= '0;
            Primed <= 1'b0;
        end else if (accept) begin
            newest <= wr_ptr;
            wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
            if (!Primed) begin
                if (n_acc == LAST_TAP)
                    Primed <= 1'b1;
                else
                    n_acc <= n_acc + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            Overrun <= 1'b0;
        else if (drop)
            Overrun <= 1'b1;
        else if (ClearOverrun)
            Overrun <= 1'b0;
    end

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        logic [TAPS-1:0][DW-1:0] hist;
        logic signed [DW-1:0]    stg;

        always_ff @(posedge Clock) begin
            if (Reset)
                hist <= '0;
            else if (accept)
                hist[wr_ptr] <= gyro_in[a];
        end

        always_ff @(posedge Clock) begin
            if (Reset)
                stg <= '0;
            else if (state == STORE && axis == 2'(a))
                stg <= res;
        end

        assign tap_val[a] = $signed(hist[rd_idx]);
        assign stg_val[a] = stg;
    end

    assign sample = (axis == 2'd0) ? tap_val[0] :
                    (axis == 2'd1) ? tap_val[1] : tap_val[2];

    gyro_fir_mac u_mac (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (acc_clr),
        .enable (mac_en),
        .coef   (coef_at(tap)),
        .sample (sample),
        .acc    (acc)
    );

    // Z is finalised on the publishing edge itself, so it bypasses its staging reg.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            GyroXOut  <= '0;
            GyroYOut  <= '0;
            GyroZOut  <= '0;
            DataReady <= 1'b0;
        end else begin
            DataReady <= publish;
            if (publish) begin
                GyroXOut <= stg_val[0];
                GyroYOut <= stg_val[1];
                GyroZOut <= res;
            end
        end
    end

endmodule
